// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, Rcon, round count and FSM encoding.
// Used by both the forward and inverse cipher tops.
package aes_pkg;

   localparam int NR_128 = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEXP  = 3'd1,
      ST_INIT  = 3'd2,
      ST_ROUND = 3'd3,
      ST_DONE  = 3'd4
   } aes_state_e;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] ISBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[8*(255-int'(b)) +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return ISBOX_TBL[8*(255-int'(b)) +: 8];
   endfunction

   // Rcon is indexed 1..10; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      if (r == 4'd0 || r > 4'd10)
         return 8'h00;
      return RCON_TBL[8*(10-int'(r)) +: 8];
   endfunction

   function automatic logic [127:0] key_next(
      input logic [127:0] k,
      input logic [7:0]   rc
   );
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]),
            sbox(w3[7:0]),   sbox(w3[31:24])};
      t  = t ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         last_i,
   output logic [127:0] state_o
);

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] m11(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] m13(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] m14(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // Byte i sits at bits [127-8i -: 8]; i = 4*col + row.
   function automatic logic [127:0] shift_sub_add(
      input logic [127:0] s,
      input logic [127:0] k
   );
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] =
               inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]) ^
               k[127-8*(4*c+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
         o[119-32*c -: 8] = m9(a0) ^ m14(a1) ^ m11(a2) ^ m13(a3);
         o[111-32*c -: 8] = m13(a0) ^ m9(a1) ^ m14(a2) ^ m11(a3);
         o[103-32*c -: 8] = m11(a0) ^ m13(a1) ^ m9(a2) ^ m14(a3);
      end
      return o;
   endfunction

   logic [127:0] ssa;

   assign ssa     = shift_sub_add(state_i, round_key_i);
   assign state_o = last_i ? ssa : inv_mix(ssa);

endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 inverse cipher with on-chip key expansion.
// Define AES_INV_KEY_CACHE_EN to reuse the last expanded key schedule.
module aes_inv_cipher_top
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic [127:0] text_out,
   output logic         done,
   output logic         busy
);

   if (NR != NR_128) begin : g_bad_nr
      $error("aes_inv_cipher_top: NR must be 10 (AES-128)");
   end

   aes_state_e   st_q, st_d;
   logic [127:0] state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] tout_q, tout_d;
   logic [127:0] rk_q [0:NR];
   logic [127:0] rk_sel;
   logic [127:0] rk_nxt;
   logic [127:0] rnd_out;
   logic         ld_cap;
   logic         kexp_we;
   logic         hit;

`ifdef AES_INV_KEY_CACHE_EN
   logic kvalid_q, kvalid_d;

   assign hit = kvalid_q && (key == rk_q[0]);

   always_comb begin
      kvalid_d = kvalid_q;
      if (ld_cap && !hit)
         kvalid_d = 1'b0;
      else if (kexp_we && round_q == 4'(NR-1))
         kvalid_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         kvalid_q <= 1'b0;
      else
         kvalid_q <= kvalid_d;
   end
`else
   assign hit = 1'b0;
`endif

   // One key mux serves both expansion (previous key) and rounds.
   always_comb begin
      rk_sel = rk_q[0];
      for (int i = 1; i <= NR; i++) begin
         if (round_q == 4'(i))
            rk_sel = rk_q[i];
      end
   end

   assign rk_nxt = key_next(rk_sel, rcon(round_q + 4'd1));

   aes_inv_round u_round (
      .state_i     (state_q),
      .round_key_i (rk_sel),
      .last_i      (round_q == 4'd0),
      .state_o     (rnd_out)
   );

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      round_d = round_q;
      tout_d  = tout_q;
      ld_cap  = 1'b0;
      kexp_we = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (ld) begin
               ld_cap  = 1'b1;
               state_d = text_in;
               round_d = 4'd0;
               st_d    = hit ? ST_INIT : ST_KEXP;
            end
         end
         ST_KEXP: begin
            kexp_we = 1'b1;
            round_d = round_q + 4'd1;
            if (round_q == 4'(NR-1))
               st_d = ST_INIT;
         end
         ST_INIT: begin
            state_d = state_q ^ rk_q[NR];
            round_d = 4'(NR-1);
            st_d    = ST_ROUND;
         end
         ST_ROUND: begin
            if (round_q == 4'd0) begin
               tout_d = rnd_out;
               st_d   = ST_DONE;
            end else begin
               state_d = rnd_out;
               round_d = round_q - 4'd1;
            end
         end
         ST_DONE: begin
            st_d = ST_IDLE;
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= ST_IDLE;
         state_q <= '0;
         round_q <= '0;
         tout_q  <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         round_q <= round_d;
         tout_q  <= tout_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++)
            rk_q[i] <= '0;
      end else begin
         if (ld_cap)
            rk_q[0] <= key;
         for (int i = 1; i <= NR; i++) begin
            if (kexp_we && round_q == 4'(i-1))
               rk_q[i] <= rk_nxt;
         end
      end
   end

   assign text_out = tout_q;
   assign done     = (st_q == ST_DONE);
   assign busy     = (st_q != ST_IDLE);

endmodule

// File: doc/aes_inv_cipher_top.md
AES_INV_CIPHER_TOP -- requirements
Module: aes_inv_cipher_top

Interface
REQ-001 Parameter: NR, 10, round count; AES-128 only; any other value is a configuration error.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ld  input  1  load strobe; sampled only in IDLE.
REQ-005 key  input  128  cipher key; sampled with ld.
REQ-006 text_in  input  128  ciphertext; sampled with ld.
REQ-007 text_out  output  128  recovered plaintext register.
REQ-008 done  output  1  one-cycle pulse when text_out becomes valid.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, KEXP, INIT, ROUND and DONE.
REQ-011 IDLE with ld=1 SHALL capture key into rk[0] and text_in into the state register, clear the round counter, and go to KEXP.
REQ-012 KEXP SHALL generate one forward round key per cycle, rk[1]..rk[NR], using RotWord/SubWord/Rcon, and SHALL go to INIT after rk[NR] is written (10 cycles).
REQ-013 INIT SHALL set state = state XOR rk[NR] and round = NR-1, then go to ROUND.
REQ-014 For round r = NR-1 down to 1, ROUND SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[r]) and InvMixColumns, in that order, then decrement round.
REQ-015 At round 0, ROUND SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(rk[0]) with no InvMixColumns, load the result into text_out, and go to DONE.
REQ-016 Latency: done SHALL be high exactly 22 cycles after the ld sampling edge when the full expansion runs.
REQ-017 DONE SHALL assert done for one cycle and then return to IDLE; text_out SHALL hold its value until the next completion.
REQ-018 ld while busy=1 SHALL be ignored, with no effect on state, keys or outputs.
REQ-019 ld in the same cycle done is high SHALL be ignored, because the FSM is not yet in IDLE.
REQ-020 Byte order SHALL be big-endian, with byte 0 at bits [127:120] in column-major FIPS-197 layout.

Reset
REQ-021 Asserting rst SHALL immediately force IDLE and clear done, busy, text_out, the state register, the round counter and the key-cache valid bit.
REQ-022 rst mid-operation SHALL abort the operation with no done pulse; the first ld after deassertion SHALL run a full-latency decryption.

Configuration
REQ-023 Macro AES_INV_KEY_CACHE_EN: when defined, the block SHALL keep the last expanded key and a valid bit.
REQ-024 With the macro defined, an ld whose key equals the cached key while valid=1 SHALL skip KEXP and go directly to INIT, giving a latency of 12 cycles.
REQ-025 With the macro defined, any other ld SHALL run KEXP and set valid=1 on completion.
REQ-026 Without the macro, KEXP SHALL run on every ld, giving a fixed latency of 22 cycles, and no cache logic SHALL be present.

Structure
REQ-027 Shared package aes_pkg SHALL hold the S-box and inverse S-box functions, the Rcon table, NR_128=10 and the FSM state encoding; the forward cipher top SHALL share this package.
REQ-028 A combinational sub-module aes_inv_round SHALL implement one inverse round, with inputs state, round_key and last, and output next state.
REQ-029 The round-key store SHALL be an 11x128 register array inside the top.

Verification
REQ-030 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, text_in 69c4e0d86a7b0430d8cdb78070b4c55a -> text_out 00112233445566778899aabbccddeeff, with done 22 cycles after ld.
REQ-031 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, text_in 3925841d02dc09fbdc118597196a0b32 -> text_out 3243f6a8885a308d313198a2e0370734.
REQ-032 ld pulsed on cycles 5 and 15 after a C.1 ld -> a single done and the C.1 result, with no restart.
REQ-033 rst asserted 8 cycles after ld -> done stays 0 and text_out=0; a following ld with B vectors -> correct B result at 22 cycles.
REQ-034 With AES_INV_KEY_CACHE_EN: two back-to-back C.1 loads -> the second done arrives at 12 cycles; then a B-key load -> 22 cycles with the correct result.
REQ-035 Round-trip: 100 random key/plaintext pairs through the forward cipher top, then through this block -> original plaintext recovered every time.
